egress_rr_scheduler: RTL and testbench
======================================

# egress_rr_scheduler

Round-robin egress scheduler that drains up to N_PORTS per-port word FIFOs onto one shared output channel. It arbitrates among non-empty, enabled ports and issues single-cycle FIFO read pulses. It captures the word one cycle later and presents it on a valid/ready output interface. Each grant may keep its port for a burst of up to MAX_BURST words before arbitration moves on. It sits between the switch's port FIFOs and the single downstream consumer.

## Interface
- N_PORTS, 4: number of source FIFOs (2..8).
- W_WIDTH, 8: word width.
- MAX_BURST, 4: maximum words per grant (≥1).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- port_en  in  N_PORTS  per-port enable; disabled ports are never granted.
- port_empty  in  N_PORTS  FIFO empty flags, 1 = empty.
- port_data  in  N_PORTS*W_WIDTH  FIFO read data, port i at bits [i*W_WIDTH +: W_WIDTH]; valid the cycle after its rd pulse.
- port_rd  out  N_PORTS  FIFO read enable, one-hot or zero.
- out_data  out  W_WIDTH  egress word.
- out_port  out  clog2(N_PORTS)  source port of out_data.
- out_valid  out  1  egress word valid.
- out_ready  in  1  downstream accepts word when out_valid & out_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD, CAP, SEND.
- eligible = ~port_empty & port_en.
- IDLE: if eligible != 0, pick the first eligible port searching upward from rr_ptr, wrapping modulo N_PORTS.
  - Load it into grant, clear burst_cnt, and go to RD.
  - Otherwise stay in IDLE.
- RD: port_rd[grant] = 1 for exactly this cycle; always go to CAP.
- CAP:
  - Register out_data <= port_data[grant] and out_port <= grant.
  - Increment burst_cnt; go to SEND.
- SEND: out_valid = 1; out_data and out_port are held stable.
  - On out_ready:
    - If burst_cnt < MAX_BURST and port_empty[grant] = 0 and port_en[grant] = 1, go to RD on the same port.
    - Otherwise set rr_ptr <= (grant+1) mod N_PORTS and go to IDLE.
  - Without out_ready, stay in SEND with all outputs frozen.
- port_rd is decoded from state only: zero outside RD, never more than one bit set.
- A read is issued only when the FIFO was sampled non-empty: in IDLE for the first word, in SEND for each later word.
- burst_cnt is clog2(MAX_BURST+1) bits wide and saturates at MAX_BURST; it cannot wrap.
- port_en falling mid-burst: the word already read is still delivered, then the burst ends at the SEND decision.
- port_empty rising mid-burst: the burst ends early and rr_ptr advances as normal.
- Reset (async, any state):
  - state = IDLE, rr_ptr = 0, grant = 0, burst_cnt = 0.
  - port_rd = 0, out_valid = 0, out_data = 0, out_port = 0, busy = 0.
  - A word already popped but not yet accepted is discarded.
- Fairness: with all ports continuously non-empty and MAX_BURST = B, ports are served in order 0,1,…,N-1,0 with B words each.

## Timing
- Cycle t, IDLE with eligible != 0 → t+1: RD with port_rd pulse → t+2: CAP → t+3: out_valid = 1.
  - Grant-to-first-word latency: 3 cycles.
- With out_ready held high:
  - Same-port burst: one word per 3 cycles (SEND→RD→CAP→SEND).
  - Port switch: 4 cycles (SEND→IDLE→RD→CAP→SEND).
- out_valid is registered and never drops without a handshake.
- port_empty and port_en changes while in RD or CAP are not looked at until SEND.
- port_data is sampled only in CAP; its value in other cycles is ignored.
- All outputs reach reset values immediately on rst_n low, without waiting for clk.
- First edge after rst_n rises: IDLE evaluation.

## Test plan
- Single word: N=4, MAX_BURST=4; only port 2 holds word 0xA5.
  - Expect: port_rd = 4'b0100 for one cycle, then out_valid 3 cycles after IDLE detect with out_data = 0xA5, out_port = 2, then IDLE with busy = 0.
- Round-robin fairness: MAX_BURST=2, all 4 ports hold 3 words, out_ready = 1.
  - Expect out_port sequence 0,0,1,1,2,2,3,3,0,1,2,3; no port_rd pulse while a port is empty.
- Backpressure: out_ready = 0 for 10 cycles during SEND.
  - Expect out_valid, out_data and out_port frozen, zero port_rd pulses; resumes on out_ready = 1 with no word lost or duplicated.
- Enable and empty edges:
  - port_en[1] deasserted while port 1 is mid-burst: the word in flight is delivered, then the grant moves to port 2.
  - Disabled non-empty port 3 is never granted.
  - A port emptying after its 1st word gives a 1-word burst.
- Reset mid-operation: assert rst_n low during CAP.
  - Expect all outputs 0 asynchronously.
  - After release, arbitration restarts from port 0 (rr_ptr = 0).

Source files
------------

// File: rtl/egress_rr_scheduler.sv
// Round-robin egress scheduler: drains per-port word FIFOs onto one valid/ready
// channel, letting each grant keep its port for up to MAX_BURST words.
module egress_rr_scheduler #(
  parameter int N_PORTS   = 4,
  parameter int W_WIDTH   = 8,
  parameter int MAX_BURST = 4,
  localparam int PW = $clog2(N_PORTS),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           port_en,
  input  logic [N_PORTS-1:0]           port_empty,
  input  logic [N_PORTS*W_WIDTH-1:0]   port_data,
  output logic [N_PORTS-1:0]           port_rd,
  output logic [W_WIDTH-1:0]           out_data,
  output logic [PW-1:0]                out_port,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  // state | meaning
  // IDLE  | no grant; search for an eligible port starting at rr_ptr
  // RD    | single-cycle read pulse to the granted FIFO
  // CAP   | FIFO word is valid; capture it into the output register
  // SEND  | word offered downstream; on handshake continue burst or release

  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       grant, grant_nxt;
  logic [PW-1:0]       rr_ptr, rr_nxt;
  logic [BW-1:0]       burst_cnt, burst_nxt;
  logic                valid_nxt;
  logic                capture;
  logic [N_PORTS-1:0]  eligible;
  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic [PW:0]         cand;
  logic [W_WIDTH-1:0]  lane [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    assign lane[i] = port_data[i*W_WIDTH +: W_WIDTH];
  end

  assign eligible = ~port_empty & port_en;
  assign busy     = (state != IDLE);

  // First eligible port at or above rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_PORTS)) cand = cand - (PW+1)'(N_PORTS);
      if (!pick_found && eligible[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    port_rd = '0;
    if (state == RD) port_rd[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    valid_nxt = out_valid;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          burst_nxt = '0;
          state_nxt = RD;
        end
      end
      RD: state_nxt = CAP;
      CAP: begin
        capture   = 1'b1;
        valid_nxt = 1'b1;
        if (burst_cnt != BW'(MAX_BURST)) burst_nxt = burst_cnt + 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if ((burst_cnt < BW'(MAX_BURST)) && !port_empty[grant] && port_en[grant]) begin
            state_nxt = RD;
          end else begin
            rr_nxt    = (grant == PW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
      out_valid <= valid_nxt;
      if (capture) begin
        out_data <= lane[grant];
        out_port <= grant;
      end
    end
  end

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Bench for egress_rr_scheduler: FIFO models per port, a word-level reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_egress_rr_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAXB = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   port_en, port_empty, port_rd;
  logic [N*W-1:0] port_data;
  logic [W-1:0]   out_data;
  logic [1:0]     out_port;
  logic           out_valid, out_ready, busy;

  egress_rr_scheduler #(.N_PORTS(N), .W_WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .port_empty(port_empty),
    .port_data(port_data), .port_rd(port_rd), .out_data(out_data),
    .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // bench-side FIFOs (what the DUT reads) and the model's own copy of their contents
  logic [W-1:0] bmem [N][DEPTH];
  int           bhd [N], bcnt [N];
  logic [W-1:0] mmem [N][DEPTH];
  int           mhd [N], mcnt [N];
  int           lane_hold [N];

  // reference model: m_age = -1 idle, 0 read cycle, 1 capture cycle, 2 word offered
  int           m_age, m_port, m_rr, m_burst, m_oport;
  logic [W-1:0] m_data, m_hold;

  int           errors = 0;
  int           checks = 0;
  int           rd_pulses = 0;
  int           hs_port [$];
  logic [W-1:0] hs_data [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int rr, input logic [N-1:0] elig);
    for (int k = 0; k < N; k++) if (elig[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic refresh_empty();
    for (int i = 0; i < N; i++) port_empty[i] = (bcnt[i] == 0);
  endtask

  task automatic push(input int p, input logic [W-1:0] d);
    bmem[p][(bhd[p] + bcnt[p]) % DEPTH] = d;
    bcnt[p]++;
    mmem[p][(mhd[p] + mcnt[p]) % DEPTH] = d;
    mcnt[p]++;
    refresh_empty();
  endtask

  task automatic model_reset();
    m_age = -1; m_port = 0; m_rr = 0; m_burst = 0; m_oport = 0;
    m_data = '0; m_hold = '0;
  endtask

  task automatic model_step();
    int p;
    case (m_age)
      -1: begin
        p = pick(m_rr, ~port_empty & port_en);
        if (p >= 0) begin m_port = p; m_burst = 0; m_age = 0; end
      end
      0: begin
        if (mcnt[m_port] > 0) begin
          m_hold = mmem[m_port][mhd[m_port]];
          mhd[m_port] = (mhd[m_port] + 1) % DEPTH;
          mcnt[m_port]--;
        end else m_hold = '0;
        m_age = 1;
      end
      1: begin
        m_data  = m_hold;
        m_oport = m_port;
        if (m_burst < MAXB) m_burst++;
        m_age = 2;
      end
      default: begin
        if (out_ready) begin
          if (m_burst < MAXB && !port_empty[m_port] && port_en[m_port]) m_age = 0;
          else begin m_rr = (m_port + 1) % N; m_age = -1; end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_rd;
    exp_rd = (m_age == 0) ? (N'(1) << m_port) : '0;
    chk("port_rd", port_rd, exp_rd);
    chk("out_valid", out_valid, m_age == 2);
    chk("busy", busy, m_age != -1);
    chk("out_data", out_data, m_data);
    chk("out_port", out_port, m_oport);
    if (port_rd != '0) rd_pulses++;
  endtask

  task automatic fifo_service();
    for (int i = 0; i < N; i++) begin
      if (lane_hold[i] > 0) lane_hold[i]--;
      else port_data[i*W +: W] = W'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (port_rd[i]) begin
        if (bcnt[i] > 0) begin
          port_data[i*W +: W] = bmem[i][bhd[i]];
          bhd[i] = (bhd[i] + 1) % DEPTH;
          bcnt[i]--;
        end else port_data[i*W +: W] = 8'hEE;
        lane_hold[i] = 2;
      end
    end
    refresh_empty();
  endtask

  task automatic cycle();
    if (rst_n && out_valid && out_ready) begin
      hs_port.push_back(int'(out_port));
      hs_data.push_back(out_data);
    end
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
    fifo_service();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", port_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_port", out_port, 0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    while (hs_port.size() < n && budget > 0) begin cycle(); budget--; end
    chk("hs_count", hs_port.size(), n);
  endtask

  task automatic drain(input int budget);
    int pend;
    pend = 1;
    while (pend != 0 && budget > 0) begin
      cycle();
      budget--;
      pend = busy;
      for (int i = 0; i < N; i++) pend += bcnt[i];
    end
    chk("drain_done", pend, 0);
  endtask

  initial begin
    int seq2 [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    int seq5 [5]  = '{0, 1, 1, 3, 3};
    logic [W-1:0] dat5 [5] = '{8'hF0, 8'hC1, 8'hC2, 8'hD1, 8'hD2};
    int cntp [N];
    int p;

    port_en = '1; port_empty = '1; port_data = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bhd[i] = 0; bcnt[i] = 0; mhd[i] = 0; mcnt[i] = 0; lane_hold[i] = 0;
    end
    model_reset();
    @(negedge clk);
    apply_reset();

    // single word on port 2
    hs_port.delete(); hs_data.delete();
    out_ready = 1'b1;
    push(2, 8'hA5);
    cycle(); chk("t1_rd", port_rd, 4'b0100); chk("t1_busy", busy, 1);
    cycle(); chk("t1_cap_rd", port_rd, 0); chk("t1_cap_valid", out_valid, 0);
    cycle(); chk("t1_valid", out_valid, 1); chk("t1_data", out_data, 8'hA5); chk("t1_port", out_port, 2);
    cycle(); chk("t1_idle_busy", busy, 0); chk("t1_idle_valid", out_valid, 0);
    chk("t1_hs", hs_port.size(), 1);

    // fairness: 3 words on every port, bursts of 2
    apply_reset();
    hs_port.delete(); hs_data.delete();
    for (int i = 0; i < N; i++) begin
      cntp[i] = 0;
      for (int k = 0; k < 3; k++) push(i, W'(16 * i + k));
    end
    rd_pulses = 0;
    wait_hs(12, 200);
    cycle(); cycle();
    chk("t2_rd_pulses", rd_pulses, 12);
    for (int i = 0; i < 12 && i < hs_port.size(); i++) begin
      chk("t2_seq", hs_port[i], seq2[i]);
      chk("t2_data", hs_data[i], 16 * seq2[i] + cntp[seq2[i]]);
      cntp[seq2[i]]++;
    end

    // backpressure: 10 stalled cycles while a word is offered
    hs_port.delete(); hs_data.delete();
    out_ready = 1'b0;
    push(0, 8'hB0); push(0, 8'hB1);
    for (int b = 0; b < 20 && !out_valid; b++) cycle();
    chk("t3_valid_seen", out_valid, 1);
    rd_pulses = 0;
    repeat (10) begin
      cycle();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 8'hB0);
    end
    chk("t3_no_rd", rd_pulses, 0);
    chk("t3_no_hs", hs_port.size(), 0);
    out_ready = 1'b1;
    wait_hs(2, 40);
    if (hs_port.size() >= 2) begin
      chk("t3_data0", hs_data[0], 8'hB0);
      chk("t3_data1", hs_data[1], 8'hB1);
    end

    // enable drop mid-burst, single-word port, disabled non-empty port
    hs_port.delete(); hs_data.delete();
    port_en = 4'b0111;
    for (int k = 0; k < 3; k++) push(3, W'(8'hD0 + k));
    for (int k = 0; k < 3; k++) push(1, W'(8'hC0 + k));
    push(2, 8'hE0);
    for (int b = 0; b < 20 && port_rd != 4'b0010; b++) cycle();
    chk("t4_p1_rd", port_rd, 4'b0010);
    port_en[1] = 1'b0;
    wait_hs(2, 60);
    repeat (20) cycle();
    chk("t4_hs_total", hs_port.size(), 2);
    chk("t4_idle", busy, 0);
    if (hs_port.size() >= 2) begin
      chk("t4_port0", hs_port[0], 1); chk("t4_data0", hs_data[0], 8'hC0);
      chk("t4_port1", hs_port[1], 2); chk("t4_data1", hs_data[1], 8'hE0);
    end

    // reset while capturing; arbitration restarts at port 0
    port_en = '1;
    push(0, 8'hF0);
    for (int b = 0; b < 10 && port_rd == '0; b++) cycle();
    chk("t5_rd", port_rd, 4'b1000);
    cycle();
    apply_reset();
    hs_port.delete(); hs_data.delete();
    cycle();
    chk("t5_restart_rd", port_rd, 4'b0001);
    drain(200);
    chk("t5_hs_total", hs_port.size(), 5);
    for (int i = 0; i < 5 && i < hs_port.size(); i++) begin
      chk("t5_seq", hs_port[i], seq5[i]);
      chk("t5_data", hs_data[i], dat5[i]);
    end

    // random traffic, enables and backpressure
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        p = $urandom_range(0, N - 1);
        if (bcnt[p] < 8) push(p, W'($urandom));
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 49) == 0) port_en[i] = ~port_en[i];
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    port_en = '1;
    out_ready = 1'b1;
    drain(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
